// File: rtl/fir_param.sv
// Direct-form FIR filter with a run-time loadable coefficient bank, a two-stage
// pipeline (products, then sum/round/saturate) and valid handshaking.
module fir_param #(
    parameter int NTAPS = 4,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int OW    = 18
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic [DW-1:0]            i_x,
    input  logic                     i_valid,
    input  logic                     i_coef_we,
    input  logic [$clog2(NTAPS)-1:0] i_coef_addr,
    input  logic [CW-1:0]            i_coef_data,
    output logic [OW-1:0]            o_y,
    output logic                     o_valid,
    output logic                     o_sat
);

    localparam int AW   = $clog2(NTAPS);
    localparam int PW   = DW + CW;
    localparam int ACCW = PW + $clog2(NTAPS);

    // tap_q[k] holds the sample accepted k+1 samples ago; the current sample
    // feeds product 0 directly from i_x.
    logic signed [DW-1:0]   tap_q  [NTAPS-1];
    logic signed [CW-1:0]   coef_q [NTAPS];
    logic signed [PW-1:0]   prod_q [NTAPS];
    logic signed [PW-1:0]   prod_d [NTAPS];
    logic                   v1_q;
    logic                   valid_q;
    logic                   sat_q;
    logic                   sat_d;
    logic [OW-1:0]          y_q;
    logic [OW-1:0]          y_d;
    logic signed [ACCW-1:0] acc_d;
    logic signed [ACCW-1:0] rnd_d;
    logic signed [ACCW-1:0] shr_d;
    logic signed [ACCW-1:0] half;
    logic signed [ACCW-1:0] sat_max;
    logic signed [ACCW-1:0] sat_min;

    function automatic logic signed [PW-1:0] mul(input logic signed [CW-1:0] c,
                                                 input logic signed [DW-1:0] x);
        logic signed [PW-1:0] ce;
        logic signed [PW-1:0] xe;
        ce = PW'(c);
        xe = PW'(x);
        return ce * xe;
    endfunction

    always_comb begin
        prod_d[0] = mul(coef_q[0], i_x);
        for (int k = 1; k < NTAPS; k++) begin
            prod_d[k] = mul(coef_q[k], tap_q[k-1]);
        end
    end

    // Full-precision sum, round half-up, then clip into OW bits.
    always_comb begin
        acc_d = '0;
        for (int k = 0; k < NTAPS; k++) begin
            acc_d = acc_d + ACCW'(prod_q[k]);
        end
        half          = '0;
        half[CW-2]    = 1'b1;
        rnd_d         = acc_d + half;
        shr_d         = rnd_d >>> (CW - 1);
        sat_max       = '0;
        sat_max[OW-2:0] = '1;
        sat_min       = '1;
        sat_min[OW-2:0] = '0;
        y_d           = shr_d[OW-1:0];
        sat_d         = 1'b0;
        if (shr_d > sat_max) begin
            y_d   = sat_max[OW-1:0];
            sat_d = 1'b1;
        end else if (shr_d < sat_min) begin
            y_d   = sat_min[OW-1:0];
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            for (int k = 0; k < NTAPS - 1; k++) tap_q[k] <= '0;
            for (int k = 0; k < NTAPS; k++) begin
                coef_q[k] <= '0;
                prod_q[k] <= '0;
            end
            v1_q    <= 1'b0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            y_q     <= '0;
        end else begin
            if (i_valid) begin
                for (int k = 0; k < NTAPS; k++) prod_q[k] <= prod_d[k];
                tap_q[0] <= i_x;
                for (int k = 1; k < NTAPS - 1; k++) tap_q[k] <= tap_q[k-1];
            end
            v1_q    <= i_valid;
            valid_q <= v1_q;
            if (v1_q) begin
                y_q   <= y_d;
                sat_q <= sat_d;
            end
            // Products above read coef_q before this write lands.
            for (int k = 0; k < NTAPS; k++) begin
                if (i_coef_we && (i_coef_addr == AW'(k))) coef_q[k] <= i_coef_data;
            end
        end
    end

    assign o_y     = y_q;
    assign o_valid = valid_q;
    assign o_sat   = sat_q;

endmodule

// File: tb/tb_fir_param.sv
// Directed bench for fir_param (NTAPS=4, DW=16, CW=16, OW=18) with hand-computed expectations.
module tb_fir_param;

    logic        clk;
    logic        i_rst;
    logic [15:0] i_x;
    logic        i_valid;
    logic        i_coef_we;
    logic [1:0]  i_coef_addr;
    logic [15:0] i_coef_data;
    logic [17:0] o_y;
    logic        o_valid;
    logic        o_sat;

    int n_checks;
    int n_fail;

    fir_param #(.NTAPS(4), .DW(16), .CW(16), .OW(18)) dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_x        (i_x),
        .i_valid    (i_valid),
        .i_coef_we  (i_coef_we),
        .i_coef_addr(i_coef_addr),
        .i_coef_data(i_coef_data),
        .o_y        (o_y),
        .o_valid    (o_valid),
        .o_sat      (o_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
    endtask

    task automatic drive(input logic [15:0] x, input logic v);
        i_x     = x;
        i_valid = v;
        step();
        i_valid = 1'b0;
    endtask

    task automatic load_coef(input logic [1:0] a, input logic [15:0] d);
        i_coef_we   = 1'b1;
        i_coef_addr = a;
        i_coef_data = d;
        step();
        i_coef_we   = 1'b0;
    endtask

    task automatic load_all(input logic [15:0] d);
        for (int k = 0; k < 4; k++) load_coef(2'(k), d);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({o_valid, o_sat, o_y} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset: got v=%b s=%b y=%h expected v=0 s=0 y=00000", o_valid, o_sat, o_y);
        end
    endtask

    task automatic test_impulse();
        logic [17:0] exp_y [5];
        exp_y = '{18'h02000, 18'h02000, 18'h02000, 18'h02000, 18'h00000};
        do_reset();
        load_all(16'h4000);
        drive(16'h4000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(16'h0000, i < 4);
            n_checks++;
            if ({o_valid, o_sat, o_y} !== {1'b1, 1'b0, exp_y[i]}) begin
                n_fail++;
                $display("FAIL impulse[%0d]: got v=%b s=%b y=%h expected v=1 s=0 y=%h", i, o_valid, o_sat, o_y, exp_y[i]);
            end
        end
        step();
        n_checks++;
        if ({o_valid, o_y} !== {1'b0, 18'h00000}) begin
            n_fail++;
            $display("FAIL impulse_idle: got v=%b y=%h expected v=0 y=00000", o_valid, o_y);
        end
    endtask

    task automatic test_latency_gaps();
        logic        pat_v [6];
        logic        exp_v [6];
        logic [17:0] exp_y [6];
        pat_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_v = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        // Second sample sees tap0 still holding the first sample: no bubbles inserted.
        exp_y = '{18'h00000, 18'h02000, 18'h02000, 18'h02000, 18'h02000, 18'h02000};
        do_reset();
        load_all(16'h4000);
        for (int i = 0; i < 6; i++) begin
            drive((i == 0) ? 16'h4000 : 16'h0000, pat_v[i]);
            n_checks++;
            if ({o_valid, o_y} !== {exp_v[i], exp_y[i]}) begin
                n_fail++;
                $display("FAIL latency[%0d]: got v=%b y=%h expected v=%b y=%h", i, o_valid, o_y, exp_v[i], exp_y[i]);
            end
        end
    endtask

    // Streams four equal samples into an all-equal bank and checks each output.
    task automatic run_step(input string name, input logic [15:0] h, input logic [15:0] x,
                            input logic [17:0] e0, input logic [17:0] e1,
                            input logic [17:0] e2, input logic [17:0] e3, input logic s3);
        logic [17:0] exp_y [4];
        logic        exp_s [4];
        exp_y = '{e0, e1, e2, e3};
        exp_s = '{1'b0, 1'b0, 1'b0, s3};
        do_reset();
        load_all(h);
        drive(x, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(x, i < 3);
            n_checks++;
            if ({o_valid, o_sat, o_y} !== {1'b1, exp_s[i], exp_y[i]}) begin
                n_fail++;
                $display("FAIL %s[%0d]: got v=%b s=%b y=%h expected v=1 s=%b y=%h", name, i, o_valid, o_sat, o_y, exp_s[i], exp_y[i]);
            end
        end
    endtask

    task automatic test_full_scale();
        run_step("full_scale", 16'h7FFF, 16'h7FFF, 18'h07FFE, 18'h0FFFC, 18'h17FFA, 18'h1FFF8, 1'b0);
    endtask

    task automatic test_saturation();
        run_step("sat_pos", 16'h8000, 16'h8000, 18'h08000, 18'h10000, 18'h18000, 18'h1FFFF, 1'b1);
        run_step("sat_neg", 16'h8000, 16'h7FFF, 18'h38001, 18'h30002, 18'h28003, 18'h20004, 1'b0);
    endtask

    task automatic test_rounding();
        do_reset();
        load_coef(2'd0, 16'h0001);
        drive(16'h4000, 1'b1);
        drive(16'h3FFF, 1'b1);
        n_checks++;
        if ({o_valid, o_y} !== {1'b1, 18'h00001}) begin
            n_fail++;
            $display("FAIL round_half: got v=%b y=%h expected v=1 y=00001", o_valid, o_y);
        end
        drive(16'h0000, 1'b0);
        n_checks++;
        if ({o_valid, o_y} !== {1'b1, 18'h00000}) begin
            n_fail++;
            $display("FAIL round_below: got v=%b y=%h expected v=1 y=00000", o_valid, o_y);
        end
    endtask

    task automatic test_coef_race();
        do_reset();
        load_all(16'h4000);
        drive(16'h4000, 1'b1);
        drive(16'h0000, 1'b1);
        i_coef_we   = 1'b1;
        i_coef_addr = 2'd2;
        i_coef_data = 16'h2000;
        drive(16'h0000, 1'b1);
        i_coef_we   = 1'b0;
        drive(16'h0000, 1'b1);
        n_checks++;
        if ({o_valid, o_y} !== {1'b1, 18'h02000}) begin
            n_fail++;
            $display("FAIL coef_old: got v=%b y=%h expected v=1 y=02000", o_valid, o_y);
        end
        drive(16'h4000, 1'b1);
        drive(16'h0000, 1'b1);
        drive(16'h0000, 1'b1);
        drive(16'h0000, 1'b0);
        n_checks++;
        if ({o_valid, o_y} !== {1'b1, 18'h01000}) begin
            n_fail++;
            $display("FAIL coef_new: got v=%b y=%h expected v=1 y=01000", o_valid, o_y);
        end
    endtask

    task automatic test_reset_midstream();
        drive(16'h4000, 1'b1);
        i_rst = 1'b1;
        drive(16'h4000, 1'b1);
        i_rst = 1'b0;
        n_checks++;
        if ({o_valid, o_y} !== {1'b0, 18'h00000}) begin
            n_fail++;
            $display("FAIL rst_flush: got v=%b y=%h expected v=0 y=00000", o_valid, o_y);
        end
        for (int i = 0; i < 3; i++) begin
            drive(16'h0000, 1'b0);
            n_checks++;
            if (o_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_no_valid[%0d]: got v=%b expected v=0", i, o_valid);
            end
        end
        drive(16'h4000, 1'b1);
        drive(16'h0000, 1'b0);
        n_checks++;
        if ({o_valid, o_sat, o_y} !== {1'b1, 1'b0, 18'h00000}) begin
            n_fail++;
            $display("FAIL rst_coef_zero: got v=%b s=%b y=%h expected v=1 s=0 y=00000", o_valid, o_sat, o_y);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        i_rst       = 1'b1;
        i_x         = '0;
        i_valid     = 1'b0;
        i_coef_we   = 1'b0;
        i_coef_addr = '0;
        i_coef_data = '0;
        test_reset();
        test_impulse();
        test_latency_gaps();
        test_full_scale();
        test_saturation();
        test_rounding();
        test_coef_race();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
